jpeg_zz_rle: RTL and testbench

Zigzag reorder and run-length/category encoder sitting directly upstream of the DARC Huffman stage in the JPEG pipeline. It accepts quantized 8x8 blocks in raster order from the quantizer partial-reconfiguration region and double-buffers them. It emits JPEG (run, size, amplitude) symbols in zigzag order, with DC differential coding, ZRL and EOB, ready for Huffman table lookup.

---
 rtl/jpeg_pkg.sv | 39 +++
 rtl/jpeg_zz_rle_if.sv | 30 +++
 rtl/jpeg_zz_buffer.sv | 54 +++++
 rtl/jpeg_zz_rle.sv | 193 +++++++++++++++++++
 tb/tb_jpeg_zz_rle.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants, zigzag LUT, read-FSM states and the magnitude-category
// helper for the zigzag/RLE stage.
package jpeg_pkg;

  localparam int unsigned COEF_W_DEF = 11;
  localparam int unsigned DIFF_W_DEF = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DC,
    S_SCAN,
    S_ZRL,
    S_EOB,
    S_LAST
  } rd_state_e;

  // Zigzag scan position -> raster (row-major) address inside an 8x8 block.
  localparam logic [5:0] ZZ_TO_RASTER [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Bit length of an unsigned magnitude; 0 maps to 0.
  function automatic logic [3:0] size_of(input logic [DIFF_W_DEF-1:0] mag);
    logic [3:0] s;
    s = '0;
    for (int unsigned i = 0; i < DIFF_W_DEF; i++) begin
      if (mag[i]) s = 4'(i + 1);
    end
    return s;
  endfunction

endpackage

// File: rtl/jpeg_zz_rle_if.sv
// Coefficient-in / symbol-out bundle of the zigzag RLE stage.
interface jpeg_zz_rle_if
  import jpeg_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned DIFF_W = DIFF_W_DEF
);
  logic              coef_valid;
  logic              coef_ready;
  logic [COEF_W-1:0] coef_data;
  logic              dc_clear;
  logic              sym_valid;
  logic              sym_ready;
  logic [3:0]        sym_run;
  logic [3:0]        sym_size;
  logic [DIFF_W-1:0] sym_amp;
  logic              sym_dc;
  logic              sym_last;

  // slave: the encoder's view; master: the surrounding pipeline's view.
  modport slave (
    input  coef_valid, coef_data, dc_clear, sym_ready,
    output coef_ready, sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_last
  );

  modport master (
    output coef_valid, coef_data, dc_clear, sym_ready,
    input  coef_ready, sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_last
  );
endinterface

// File: rtl/jpeg_zz_buffer.sv
// Ping-pong 8x8 block store: raster-order write side, asynchronous read port.
module jpeg_zz_buffer #(
  parameter int unsigned COEF_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [COEF_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [5:0]        rd_addr,
  output logic [COEF_W-1:0] rd_data,
  output logic              rd_full,
  input  logic              rd_release
);

  logic [COEF_W-1:0] mem [2][64];
  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [5:0]        wr_cnt;
  logic              wr_fire;

  assign wr_ready = !full[wr_bank];
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_full  = full[rd_bank];
  assign rd_data  = mem[rd_bank][rd_addr];

  // Storage is not reset; the full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_cnt] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 6'd1;
        if (wr_cnt == 6'd63) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (rd_release) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

endmodule

// File: rtl/jpeg_zz_rle.sv
// Zigzag reorder + JPEG run/size/amplitude symbol generator with DC
// differential coding, ZRL and EOB, feeding the Huffman stage.
module jpeg_zz_rle
  import jpeg_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned DIFF_W = DIFF_W_DEF
) (
  input  logic          ACLK,
  input  logic          ARESET,
  jpeg_zz_rle_if.slave  bus
);

  rd_state_e         state, state_n;
  logic [5:0]        idx, idx_n;
  logic [5:0]        run, run_n;
  logic [COEF_W-1:0] pred;
  logic [COEF_W-1:0] cur;
  logic              rd_full;
  logic              rd_release;

  logic              sym_valid;
  logic [3:0]        sym_run, sym_size;
  logic [DIFF_W-1:0] sym_amp;
  logic              sym_dc, sym_last;

  logic              emit, coef_go, pred_ld, adv, cur_zero;
  logic [3:0]        e_run, e_size;
  logic [DIFF_W-1:0] e_amp;
  logic              e_dc, e_last;

  logic [DIFF_W-1:0] cur_x, pred_x, dc_diff, val, mag, mask, amp;
  logic [3:0]        sz;

  jpeg_zz_buffer #(.COEF_W(COEF_W)) u_buf (
    .clk        (ACLK),
    .rst        (ARESET),
    .wr_valid   (bus.coef_valid),
    .wr_data    (bus.coef_data),
    .wr_ready   (bus.coef_ready),
    .rd_addr    (ZZ_TO_RASTER[idx]),
    .rd_data    (cur),
    .rd_full    (rd_full),
    .rd_release (rd_release)
  );

  assign adv      = !sym_valid || bus.sym_ready;
  assign cur_zero = (cur == '0);

  // Category/amplitude: DC uses the predictor difference, AC the coefficient.
  always_comb begin
    cur_x   = {{(DIFF_W-COEF_W){cur[COEF_W-1]}}, cur};
    pred_x  = {{(DIFF_W-COEF_W){pred[COEF_W-1]}}, pred};
    dc_diff = cur_x - pred_x;
    val     = (state == S_DC) ? dc_diff : cur_x;
    mag     = val[DIFF_W-1] ? (~val + DIFF_W'(1)) : val;
    sz      = size_of(mag);
    mask    = (DIFF_W'(1) << sz) - DIFF_W'(1);
    amp     = val[DIFF_W-1] ? ((val - DIFF_W'(1)) & mask) : val;
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    run_n      = run;
    emit       = 1'b0;
    e_run      = '0;
    e_size     = '0;
    e_amp      = '0;
    e_dc       = 1'b0;
    e_last     = 1'b0;
    pred_ld    = 1'b0;
    rd_release = 1'b0;
    coef_go    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_full) begin
          state_n = S_DC;
          idx_n   = '0;
        end
      end
      S_DC: begin
        if (adv) begin
          emit    = 1'b1;
          e_size  = sz;
          e_amp   = amp;
          e_dc    = 1'b1;
          pred_ld = 1'b1;
          idx_n   = 6'd1;
          run_n   = '0;
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        // Zeros advance regardless of downstream backpressure.
        if (cur_zero) begin
          run_n = run + 6'd1;
          if (idx == 6'd63) state_n = S_EOB;
          else              idx_n   = idx + 6'd1;
        end else if (run >= 6'd16) begin
          state_n = S_ZRL;
        end else begin
          coef_go = adv;
        end
      end
      S_ZRL: begin
        if (run >= 6'd16) begin
          if (adv) begin
            emit  = 1'b1;
            e_run = 4'd15;
            run_n = run - 6'd16;
          end
        end else begin
          coef_go = adv;
        end
      end
      S_EOB: begin
        if (adv) begin
          emit    = 1'b1;
          e_last  = 1'b1;
          state_n = S_LAST;
        end
      end
      S_LAST: begin
        if (sym_valid && bus.sym_ready) begin
          rd_release = 1'b1;
          state_n    = S_IDLE;
          idx_n      = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Nonzero AC emission shared by SCAN and the tail of a ZRL sequence.
    if (coef_go) begin
      emit   = 1'b1;
      e_run  = run[3:0];
      e_size = sz;
      e_amp  = amp;
      run_n  = '0;
      if (idx == 6'd63) begin
        e_last  = 1'b1;
        state_n = S_LAST;
      end else begin
        idx_n   = idx + 6'd1;
        state_n = S_SCAN;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= S_IDLE;
      idx   <= '0;
      run   <= '0;
      pred  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      run   <= run_n;
      if (bus.dc_clear)  pred <= '0;
      else if (pred_ld)  pred <= cur;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sym_valid <= 1'b0;
      sym_run   <= '0;
      sym_size  <= '0;
      sym_amp   <= '0;
      sym_dc    <= 1'b0;
      sym_last  <= 1'b0;
    end else if (emit) begin
      sym_valid <= 1'b1;
      sym_run   <= e_run;
      sym_size  <= e_size;
      sym_amp   <= e_amp;
      sym_dc    <= e_dc;
      sym_last  <= e_last;
    end else if (sym_valid && bus.sym_ready) begin
      sym_valid <= 1'b0;
    end
  end

  assign bus.sym_valid = sym_valid;
  assign bus.sym_run   = sym_run;
  assign bus.sym_size  = sym_size;
  assign bus.sym_amp   = sym_amp;
  assign bus.sym_dc    = sym_dc;
  assign bus.sym_last  = sym_last;

endmodule

// File: tb/tb_jpeg_zz_rle.sv
// Directed bench for jpeg_zz_rle: block table with hand-computed symbols plus
// latency, backpressure, reset and DC-predictor-clear sequences.
module tb_jpeg_zz_rle;
  import jpeg_pkg::*;

  typedef struct packed {
    logic [3:0]  run;
    logic [3:0]  size;
    logic [11:0] amp;
    logic        dc;
    logic        last;
  } sym_t;

  // Raster value c0 at position 0, optional (p,v) pairs elsewhere (p=0 unused).
  typedef struct packed {
    int c0;
    int p1; int v1;
    int p2; int v2;
    int p3; int v3;
    int n;
  } tc_t;

  logic tb_ACLK = 1'b0;
  logic ARESET;
  always #5 tb_ACLK = ~tb_ACLK;

  jpeg_zz_rle_if #(.COEF_W(11), .DIFF_W(12)) bus ();

  jpeg_zz_rle #(.COEF_W(11), .DIFF_W(12)) dut (
    .ACLK   (tb_ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  int   errors = 0;
  int   checks = 0;
  tc_t  tab [8];
  sym_t exp_q [$];

  function automatic sym_t S(int r, int s, int a, bit dc, bit last);
    sym_t x;
    x.run  = 4'(r);
    x.size = 4'(s);
    x.amp  = 12'(a);
    x.dc   = dc;
    x.last = last;
    return x;
  endfunction

  function automatic sym_t cur_sym();
    return {bus.sym_run, bus.sym_size, bus.sym_amp, bus.sym_dc, bus.sym_last};
  endfunction

  function automatic int coef_at(tc_t t, int r);
    if (r == 0) return t.c0;
    if (t.p1 != 0 && r == t.p1) return t.v1;
    if (t.p2 != 0 && r == t.p2) return t.v2;
    if (t.p3 != 0 && r == t.p3) return t.v3;
    return 0;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic check_sym(input string name, input sym_t act, input sym_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got run=%0d size=%0d amp=%0d dc=%0b last=%0b, required run=%0d size=%0d amp=%0d dc=%0b last=%0b",
               name, act.run, act.size, act.amp, act.dc, act.last,
               req.run, req.size, req.amp, req.dc, req.last);
    end
  endtask

  task automatic send_coef(input logic [10:0] d);
    int cyc;
    cyc = 0;
    @(negedge tb_ACLK);
    bus.coef_valid = 1'b1;
    bus.coef_data  = d;
    while (!bus.coef_ready && cyc < 200) begin
      @(negedge tb_ACLK);
      cyc++;
    end
    if (!bus.coef_ready) begin
      checks++;
      errors++;
      $display("FAIL coef_ready_timeout: got coef_ready=0 for %0d cycles, required 1", cyc);
      bus.coef_valid = 1'b0;
      return;
    end
    @(posedge tb_ACLK);
    #1;
    bus.coef_valid = 1'b0;
  endtask

  task automatic send_block(input tc_t t, input int count);
    for (int r = 0; r < count; r++) send_coef(11'(coef_at(t, r)));
  endtask

  // Waits for a symbol, optionally holds sym_ready low for 'hold' cycles
  // checking field stability, then accepts exactly that one symbol.
  task automatic get_sym(input int hold, output sym_t s, output bit ok);
    int cyc;
    bit stable;
    ok  = 1'b0;
    s   = '0;
    cyc = 0;
    @(negedge tb_ACLK);
    while (!bus.sym_valid && cyc < 400) begin
      @(negedge tb_ACLK);
      cyc++;
    end
    if (!bus.sym_valid) begin
      checks++;
      errors++;
      $display("FAIL sym_valid_timeout: got sym_valid=0 for %0d cycles, required 1", cyc);
      return;
    end
    s = cur_sym();
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge tb_ACLK);
        if (!bus.sym_valid || cur_sym() !== s) stable = 1'b0;
      end
      check_bit("hold_stable", stable, 1'b1);
    end
    bus.sym_ready = 1'b1;
    @(posedge tb_ACLK);
    #1;
    bus.sym_ready = 1'b0;
    ok = 1'b1;
  endtask

  task automatic expect_sym(input string name, input int hold, input sym_t e);
    sym_t s;
    bit   ok;
    get_sym(hold, s, ok);
    if (ok) check_sym(name, s, e);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    tc_t  t;

    // pred runs 0 -> 5 -> 3 -> 3 -> 3 -> -1024 -> 1023 -> 1023 -> -2
    tab[0] = '{c0:5,     p1:0,  v1:0,    p2:0,  v2:0,     p3:0, v3:0, n:2};
    tab[1] = '{c0:3,     p1:0,  v1:0,    p2:0,  v2:0,     p3:0, v3:0, n:2};
    tab[2] = '{c0:3,     p1:1,  v1:-1,   p2:40, v2:7,     p3:0, v3:0, n:5};
    tab[3] = '{c0:3,     p1:63, v1:1,    p2:0,  v2:0,     p3:0, v3:0, n:5};
    tab[4] = '{c0:-1024, p1:1,  v1:1023, p2:8,  v2:-1024, p3:0, v3:0, n:4};
    tab[5] = '{c0:1023,  p1:12, v1:2,    p2:63, v2:-1,    p3:0, v3:0, n:5};
    tab[6] = '{c0:1023,  p1:19, v1:-3,   p2:0,  v2:0,     p3:0, v3:0, n:4};
    tab[7] = '{c0:-2,    p1:2,  v1:4,    p2:3,  v2:-4,    p3:0, v3:0, n:4};
    exp_q = '{
      S(0,3,5,1,0),     S(0,0,0,0,1),
      S(0,2,1,1,0),     S(0,0,0,0,1),
      S(0,0,0,1,0),     S(0,1,0,0,0),    S(15,0,0,0,0), S(2,3,7,0,0),  S(0,0,0,0,1),
      S(0,0,0,1,0),     S(15,0,0,0,0),   S(15,0,0,0,0), S(15,0,0,0,0), S(14,1,1,0,1),
      S(0,11,1020,1,0), S(0,10,1023,0,0), S(0,11,1023,0,0), S(0,0,0,0,1),
      S(0,11,2047,1,0), S(15,2,2,0,0),   S(15,0,0,0,0), S(15,0,0,0,0), S(14,1,0,0,1),
      S(0,0,0,1,0),     S(15,0,0,0,0),   S(0,2,0,0,0),  S(0,0,0,0,1),
      S(0,11,1022,1,0), S(4,3,4,0,0),    S(0,3,3,0,0),  S(0,0,0,0,1)
    };

    ARESET         = 1'b1;
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;
    bus.dc_clear   = 1'b0;
    bus.sym_ready  = 1'b0;
    repeat (3) @(posedge tb_ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge tb_ACLK);
    check_bit("reset_coef_ready", bus.coef_ready, 1'b1);
    check_bit("reset_sym_valid", bus.sym_valid, 1'b0);
    check_sym("reset_fields", cur_sym(), S(0,0,0,0,0));

    // All-zero block with DC latency: valid rises on the 2nd edge after the 64th handshake.
    t = '{c0:0, p1:0, v1:0, p2:0, v2:0, p3:0, v3:0, n:2};
    send_block(t, 64);
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    check_bit("lat_before_dc", bus.sym_valid, 1'b0);
    @(negedge tb_ACLK);
    check_bit("lat_dc_valid", bus.sym_valid, 1'b1);
    expect_sym("zero_dc", 0, S(0,0,0,1,0));
    expect_sym("zero_eob", 0, S(0,0,0,0,1));

    k = 0;
    for (int i = 0; i < 8; i++) begin
      send_block(tab[i], 64);
      for (int j = 0; j < tab[i].n; j++) begin
        expect_sym($sformatf("blk%0d_sym%0d", i, j), 0, exp_q[k]);
        k++;
      end
    end

    // Double buffering: A and B both load while A's DC is stalled; a third block must wait.
    t = '{c0:100, p1:1, v1:-1, p2:40, v2:7, p3:0, v3:0, n:5};
    send_block(t, 64);
    t = '{c0:100, p1:0, v1:0, p2:0, v2:0, p3:0, v3:0, n:2};
    send_block(t, 64);
    @(negedge tb_ACLK);
    check_bit("third_block_blocked", bus.coef_ready, 1'b0);
    expect_sym("bpA_dc", 10, S(0,7,102,1,0));
    expect_sym("bpA_ac1", 0, S(0,1,0,0,0));
    expect_sym("bpA_zrl", 10, S(15,0,0,0,0));
    expect_sym("bpA_ac20", 0, S(2,3,7,0,0));
    check_bit("ready_low_before_last", bus.coef_ready, 1'b0);
    expect_sym("bpA_eob", 0, S(0,0,0,0,1));
    check_bit("ready_after_last", bus.coef_ready, 1'b1);
    expect_sym("bpB_dc", 0, S(0,0,0,1,0));
    expect_sym("bpB_eob", 0, S(0,0,0,0,1));
    t = '{c0:-5, p1:0, v1:0, p2:0, v2:0, p3:0, v3:0, n:2};
    send_block(t, 64);
    expect_sym("bpC_dc", 0, S(0,7,22,1,0));
    expect_sym("bpC_eob", 0, S(0,0,0,0,1));

    // Reset after 30 coefficients: partial block and predictor are discarded.
    t = '{c0:77, p1:5, v1:9, p2:0, v2:0, p3:0, v3:0, n:0};
    send_block(t, 30);
    @(negedge tb_ACLK);
    ARESET = 1'b1;
    @(negedge tb_ACLK);
    check_bit("midrst_coef_ready", bus.coef_ready, 1'b1);
    check_bit("midrst_sym_valid", bus.sym_valid, 1'b0);
    check_sym("midrst_fields", cur_sym(), S(0,0,0,0,0));
    ARESET = 1'b0;
    t = '{c0:6, p1:0, v1:0, p2:0, v2:0, p3:0, v3:0, n:2};
    send_block(t, 64);
    expect_sym("postrst_dc", 0, S(0,3,6,1,0));
    expect_sym("postrst_eob", 0, S(0,0,0,0,1));

    // dc_clear pulse between blocks.
    @(negedge tb_ACLK);
    bus.dc_clear = 1'b1;
    @(negedge tb_ACLK);
    bus.dc_clear = 1'b0;
    send_block(t, 64);
    expect_sym("clr_dc", 0, S(0,3,6,1,0));
    expect_sym("clr_eob", 0, S(0,0,0,0,1));

    // dc_clear on the DC emission edge wins over the predictor update.
    t = '{c0:9, p1:0, v1:0, p2:0, v2:0, p3:0, v3:0, n:2};
    send_block(t, 64);
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    bus.dc_clear = 1'b1;
    @(posedge tb_ACLK);
    #1;
    bus.dc_clear = 1'b0;
    expect_sym("coin_dc", 0, S(0,2,3,1,0));
    expect_sym("coin_eob", 0, S(0,0,0,0,1));
    send_block(t, 64);
    expect_sym("coin_next_dc", 0, S(0,4,9,1,0));
    expect_sym("coin_next_eob", 0, S(0,0,0,0,1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
